// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: command-driven Johnson (twisted-ring) counter sequencer.
// Commands (STOP/RUN/STEP/LOAD) arrive over a valid/ready handshake. The
// block applies a prescaler and a direction, and reports the phase index,
// busy and a done pulse.
// Optional build macro JSEQ_SELF_CORRECT_EN: illegal (non-Johnson) register
// contents are forced to zero and flagged on err. Without it err is tied 0.
module johnson_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic                          cmd_dir,
    input  logic [DIV_W-1:0]              cmd_div,
    input  logic [WIDTH-1:0]              cmd_data,
    output logic [WIDTH-1:0]              jc_q,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int PIDX_W = $clog2(2*WIDTH);
    localparam logic [PIDX_W:0] TWO_W = (PIDX_W+1)'(2*WIDTH);

    localparam logic [1:0] OP_STOP = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   jc_n;
    logic [DIV_W-1:0]   pre_q, pre_n;
    logic [DIV_W-1:0]   div_q, div_n;
    logic               dir_q, dir_n;
    logic [WIDTH-1:0]   rem_q, rem_n;
    logic               done_n;
    logic               accept;
    logic [WIDTH-1:0]   jc_adv;
    logic [PIDX_W:0]    ones;
    logic [PIDX_W:0]    idx_full;

    // Handshake and status are pure functions of the state.
    assign cmd_ready = (state != S_STEP);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // One-step advance in the latched direction; reverse undoes forward.
    assign jc_adv = dir_q ? {~jc_q[0], jc_q[WIDTH-1:1]}
                          : {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};

    // Phase decode: popcount gives distance from the all-zero/all-one
    // corner; bit 0 tells which half of the ring we are on.
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++)
            ones = ones + {{PIDX_W{1'b0}}, jc_q[i]};
        if (jc_q[0])
            idx_full = ones;
        else if (ones == '0)
            idx_full = '0;
        else
            idx_full = TWO_W - ones;
    end
    assign phase_idx = idx_full[PIDX_W-1:0];

`ifdef JSEQ_SELF_CORRECT_EN
    logic            err_q, err_n;
    logic [PIDX_W:0] n_trans;
    logic            illegal;

    // Count adjacent-bit transitions; a Johnson pattern has at most one.
    always_comb begin
        n_trans = '0;
        for (int i = 0; i < WIDTH-1; i++)
            n_trans = n_trans + {{PIDX_W{1'b0}}, jc_q[i] ^ jc_q[i+1]};
    end
    assign illegal = (n_trans > (PIDX_W+1)'(1));
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state: prescaled advance, command handling, optional correction.
    always_comb begin
        state_n = state;
        jc_n    = jc_q;
        pre_n   = pre_q;
        div_n   = div_q;
        dir_n   = dir_q;
        rem_n   = rem_q;
        done_n  = 1'b0;
`ifdef JSEQ_SELF_CORRECT_EN
        err_n   = 1'b0;
`endif

        if (state == S_RUN || state == S_STEP) begin
            if (pre_q == '0) begin
                jc_n  = jc_adv;
                pre_n = div_q;
                if (state == S_STEP) begin
                    rem_n = rem_q - WIDTH'(1);
                    if (rem_q == WIDTH'(1)) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end else begin
                pre_n = pre_q - DIV_W'(1);
            end
        end

        // An accepted command owns this edge: no advance alongside it.
        if (accept) begin
            jc_n = jc_q;
            unique case (cmd_op)
                OP_STOP: state_n = S_IDLE;
                OP_RUN: begin
                    state_n = S_RUN;
                    dir_n   = cmd_dir;
                    div_n   = cmd_div;
                    pre_n   = cmd_div;
                end
                OP_STEP: begin
                    if (cmd_data == '0) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_STEP;
                        dir_n   = cmd_dir;
                        div_n   = cmd_div;
                        pre_n   = cmd_div;
                        rem_n   = cmd_data;
                    end
                end
                OP_LOAD: begin
                    state_n = S_IDLE;
                    jc_n    = cmd_data;
                end
                default: state_n = state;
            endcase
        end

`ifdef JSEQ_SELF_CORRECT_EN
        // Correction wins over any advance or load at this edge.
        if (illegal) begin
            jc_n  = '0;
            err_n = 1'b1;
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            jc_q  <= '0;
            pre_q <= '0;
            div_q <= '0;
            dir_q <= 1'b0;
            rem_q <= '0;
            done  <= 1'b0;
`ifdef JSEQ_SELF_CORRECT_EN
            err_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            jc_q  <= jc_n;
            pre_q <= pre_n;
            div_q <= div_n;
            dir_q <= dir_n;
            rem_q <= rem_n;
            done  <= done_n;
`ifdef JSEQ_SELF_CORRECT_EN
            err_q <= err_n;
`endif
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl (WIDTH=8, DIV_W=4). Inputs change and
// outputs are sampled on the falling edge.
module tb_johnson_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic [3:0] cmd_div;
    logic [7:0] cmd_data;
    logic [7:0] jc_q;
    logic [3:0] phase_idx;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    johnson_seq_ctrl #(.WIDTH(8), .DIV_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_div(cmd_div),
        .cmd_data(cmd_data),
        .jc_q(jc_q), .phase_idx(phase_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with ready known high; returns at the falling
    // edge right after the accepting rising edge.
    task automatic issue(input logic [1:0] op, input logic dir,
                         input logic [3:0] div, input logic [7:0] data);
        chk("ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_div   = div;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    logic [7:0] fwd_seq [16];
    logic [7:0] e_jc;
    logic       done_seen;

    initial begin
        fwd_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dir = 1'b0;
        cmd_div = 4'd0; cmd_data = 8'd0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_jc",    {24'b0, jc_q}, 32'h00);
        chk("rst_phase", {28'b0, phase_idx}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_err",   {31'b0, err}, 32'd0);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // RUN forward D=0: one advance per cycle around the full ring
        issue(2'd1, 1'b0, 4'd0, 8'd0);
        chk("run_accept_jc", {24'b0, jc_q}, 32'h00);
        chk("run_busy",      {31'b0, busy}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("run_jc_%0d", k + 1), {24'b0, jc_q}, {24'b0, fwd_seq[k]});
            chk($sformatf("run_phase_%0d", k + 1), {28'b0, phase_idx},
                (k + 1) % 16);
        end
        chk("run_busy_end", {31'b0, busy}, 32'd1);
        chk("run_ready", {31'b0, cmd_ready}, 32'd1);
        issue(2'd0, 1'b0, 4'd0, 8'd0);
        chk("stop1_jc",   {24'b0, jc_q}, 32'h00);
        chk("stop1_busy", {31'b0, busy}, 32'd0);

        // LOAD 0x0F then STEP N=3 reverse D=2
        issue(2'd3, 1'b0, 4'd0, 8'h0F);
        chk("load_jc",    {24'b0, jc_q}, 32'h0F);
        chk("load_phase", {28'b0, phase_idx}, 32'd4);
        issue(2'd2, 1'b1, 4'd2, 8'd3);
        chk("step_acc_jc",    {24'b0, jc_q}, 32'h0F);
        chk("step_acc_ready", {31'b0, cmd_ready}, 32'd0);
        chk("step_acc_busy",  {31'b0, busy}, 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            e_jc = (k < 3) ? 8'h0F : (k < 6) ? 8'h07 : (k < 9) ? 8'h03 : 8'h01;
            chk($sformatf("step_jc_%0d", k),    {24'b0, jc_q}, {24'b0, e_jc});
            chk($sformatf("step_done_%0d", k),  {31'b0, done}, (k == 9) ? 1 : 0);
            chk($sformatf("step_ready_%0d", k), {31'b0, cmd_ready}, (k == 9) ? 1 : 0);
            chk($sformatf("step_busy_%0d", k),  {31'b0, busy}, (k == 9) ? 0 : 1);
        end
        chk("step_phase", {28'b0, phase_idx}, 32'd1);
        @(negedge clk);
        chk("step_done_clear", {31'b0, done}, 32'd0);
        chk("step_hold_jc",    {24'b0, jc_q}, 32'h01);

        // STEP N=0: immediate done, nothing moves
        issue(2'd2, 1'b0, 4'd0, 8'd0);
        chk("step0_done", {31'b0, done}, 32'd1);
        chk("step0_jc",   {24'b0, jc_q}, 32'h01);
        chk("step0_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("step0_done_clear", {31'b0, done}, 32'd0);
        chk("step0_jc2",        {24'b0, jc_q}, 32'h01);

        // RUN D=1 then STOP five cycles after the accept
        issue(2'd1, 1'b0, 4'd1, 8'd0);
        @(negedge clk);
        chk("run1_e1", {24'b0, jc_q}, 32'h01);
        @(negedge clk);
        chk("run1_e2", {24'b0, jc_q}, 32'h03);
        @(negedge clk);
        chk("run1_e3", {24'b0, jc_q}, 32'h03);
        @(negedge clk);
        chk("run1_e4", {24'b0, jc_q}, 32'h07);
        issue(2'd0, 1'b0, 4'd0, 8'd0);
        chk("stop2_jc",   {24'b0, jc_q}, 32'h07);
        chk("stop2_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("stop2_frozen", {24'b0, jc_q}, 32'h07);
        issue(2'd1, 1'b0, 4'd0, 8'd0);
        @(negedge clk);
        chk("resume_jc", {24'b0, jc_q}, 32'h0F);
        issue(2'd0, 1'b0, 4'd0, 8'd0);
        chk("stop3_jc", {24'b0, jc_q}, 32'h0F);

        // Reverse wrap 0 -> 15
        issue(2'd3, 1'b0, 4'd0, 8'h00);
        issue(2'd2, 1'b1, 4'd0, 8'd1);
        @(negedge clk);
        chk("rev_wrap_jc",    {24'b0, jc_q}, 32'h80);
        chk("rev_wrap_phase", {28'b0, phase_idx}, 32'd15);
        chk("rev_wrap_done",  {31'b0, done}, 32'd1);
        @(negedge clk);

        // LOAD illegal pattern 0x05
        issue(2'd3, 1'b0, 4'd0, 8'h05);
        chk("ill_load_jc", {24'b0, jc_q}, 32'h05);
        chk("ill_load_err", {31'b0, err}, 32'd0);
        @(negedge clk);
`ifdef JSEQ_SELF_CORRECT_EN
        chk("ill_fix_jc",  {24'b0, jc_q}, 32'h00);
        chk("ill_fix_err", {31'b0, err}, 32'd1);
        @(negedge clk);
        chk("ill_err_clear", {31'b0, err}, 32'd0);
        chk("ill_jc_stay",   {24'b0, jc_q}, 32'h00);
`else
        chk("ill_keep_jc",  {24'b0, jc_q}, 32'h05);
        chk("ill_keep_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        chk("ill_keep_jc2", {24'b0, jc_q}, 32'h05);
`endif

        // Reset in the middle of a long STEP
        issue(2'd3, 1'b0, 4'd0, 8'h00);
        issue(2'd2, 1'b0, 4'd0, 8'd200);
        repeat (10) @(negedge clk);
        chk("long_busy",  {31'b0, busy}, 32'd1);
        chk("long_ready", {31'b0, cmd_ready}, 32'd0);
        chk("long_jc",    {24'b0, jc_q}, 32'hFC);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_jc",    {24'b0, jc_q}, 32'h00);
        chk("mid_rst_busy",  {31'b0, busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("mid_rst_done",  {31'b0, done}, 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        chk("mid_rst_no_done", {31'b0, done_seen}, 32'd0);
        chk("mid_rst_jc_hold", {24'b0, jc_q}, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
